// File: rtl/qnigma_rtr_sol.sv
// Router Solicitation scheduler. After link-up it waits a pseudo-random
// delay, then requests RS transmissions at a fixed interval until the
// router-information stage reports a router. An unanswered burst raises
// rs_fail, backs off, and then restarts. Losing a detected router
// re-arms the random delay.
module qnigma_rtr_sol #(
  parameter int          RS_MAX        = 3,
  parameter int          RS_INTERVAL_S = 4,
  parameter int          RS_BACKOFF_S  = 60,
  parameter int          DLY_W         = 10,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_ms,
  input  logic       tick_s,
  input  logic       en,
  input  logic       rtr_det,
  output logic       rs_req,
  input  logic       rs_ack,
  output logic [7:0] rs_cnt,
  output logic       rs_fail,
  output logic       sol_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_FAIL  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0]       RS_MAX_C  = 8'(RS_MAX);
  localparam logic [15:0]      IVL_C     = 16'(RS_INTERVAL_S);
  localparam logic [15:0]      BO_C      = 16'(RS_BACKOFF_S);
  localparam logic [DLY_W-1:0] DLY_ONE   = {{(DLY_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [15:0]      ivl_q, ivl_d;
  logic [15:0]      bo_q, bo_d;
  logic             req_q, req_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;

  // Galois form of x^16+x^14+x^13+x^11+1; a non-zero seed never reaches 0
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // LFSR free-runs every clock outside reset
  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= SEED;
    else      lfsr_q <= lfsr_d;
  end

  // Next-state and next-output logic; outputs are registered from these
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    ivl_d   = ivl_q;
    bo_d    = bo_q;
    req_d   = 1'b0;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    done_d  = done_q;

    if (!en) begin
      // Link down beats everything, including a same-cycle ack
      state_d = S_IDLE;
      dly_d   = '0;
      ivl_d   = '0;
      bo_d    = '0;
      cnt_d   = '0;
      fail_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          dly_d   = lfsr_q[DLY_W-1:0];
          state_d = S_DELAY;
        end

        S_DELAY: begin
          if (rtr_det) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else if (dly_q == '0) begin
            state_d = S_SEND;
            req_d   = 1'b1;
          end else if (tick_ms) begin
            dly_d = dly_q - DLY_ONE;
          end
        end

        S_SEND: begin
          // Request stays up until accepted, even if a router shows up
          req_d = 1'b1;
          if (rs_ack && req_q) begin
            req_d = 1'b0;
            cnt_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
            ivl_d = IVL_C;
            if (rtr_det) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (rtr_det) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else if (ivl_q == '0) begin
            if (cnt_q < RS_MAX_C) begin
              state_d = S_SEND;
              req_d   = 1'b1;
            end else begin
              state_d = S_FAIL;
              bo_d    = BO_C;
              fail_d  = 1'b1;
            end
          end else if (tick_s) begin
            ivl_d = ivl_q - 16'd1;
          end
        end

        S_FAIL: begin
          fail_d = 1'b1;
          if (rtr_det) begin
            state_d = S_DONE;
            fail_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else if (bo_q == '0) begin
            state_d = S_SEND;
            fail_d  = 1'b0;
            cnt_d   = '0;
            req_d   = 1'b1;
          end else if (tick_s) begin
            bo_d = bo_q - 16'd1;
          end
        end

        S_DONE: begin
          done_d = 1'b1;
          cnt_d  = '0;
          if (!rtr_det) begin
            // Router expired: re-arm with a fresh random delay
            done_d  = 1'b0;
            dly_d   = lfsr_q[DLY_W-1:0];
            state_d = S_DELAY;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      ivl_q   <= '0;
      bo_q    <= '0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      ivl_q   <= ivl_d;
      bo_q    <= bo_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
    end
  end

  assign rs_req   = req_q;
  assign rs_cnt   = cnt_q;
  assign rs_fail  = fail_q;
  assign sol_done = done_q;

endmodule

// File: tb/tb_qnigma_rtr_sol.sv
// Directed bench for the RS scheduler: delay, burst, failure/backoff,
// router detect/expire, link-down and reset paths.
module tb_qnigma_rtr_sol;
  localparam int          RS_MAX        = 3;
  localparam int          RS_INTERVAL_S = 4;
  localparam int          RS_BACKOFF_S  = 5;
  localparam int          DLY_W         = 4;
  localparam logic [15:0] SEED          = 16'h0001;

  localparam int ST_IDLE  = 0;
  localparam int ST_DELAY = 1;
  localparam int ST_SEND  = 2;
  localparam int ST_WAIT  = 3;
  localparam int ST_FAIL  = 4;
  localparam int ST_DONE  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_ms = 1'b0;
  logic       tick_s = 1'b0;
  logic       en = 1'b0;
  logic       rtr_det = 1'b0;
  logic       rs_ack = 1'b0;
  logic       rs_req;
  logic [7:0] rs_cnt;
  logic       rs_fail;
  logic       sol_done;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] m_lfsr;
  logic [3:0]  d;

  qnigma_rtr_sol #(
    .RS_MAX(RS_MAX), .RS_INTERVAL_S(RS_INTERVAL_S), .RS_BACKOFF_S(RS_BACKOFF_S),
    .DLY_W(DLY_W), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .tick_s(tick_s), .en(en),
    .rtr_det(rtr_det), .rs_req(rs_req), .rs_ack(rs_ack), .rs_cnt(rs_cnt),
    .rs_fail(rs_fail), .sol_done(sol_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR built from the polynomial definition
  always @(posedge clk) m_lfsr <= !rst ? SEED : lfsr_step(m_lfsr);

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input int req, input int cnt, input int fail, input int done);
    chk({tag, ".rs_req"},   32'(rs_req),   32'(req));
    chk({tag, ".rs_cnt"},   32'(rs_cnt),   32'(cnt));
    chk({tag, ".rs_fail"},  32'(rs_fail),  32'(fail));
    chk({tag, ".sol_done"}, 32'(sol_done), 32'(done));
  endtask

  task automatic tick_sec();
    tick_s = 1'b1; step(1); tick_s = 1'b0; step(9);
  endtask

  // Counts the delay down with spaced ms ticks; request must rise one clk after zero
  task automatic run_delay(input string tag, input logic [3:0] dd);
    for (int i = 0; i < int'(dd); i++) begin
      tick_ms = 1'b1; step(1); tick_ms = 1'b0;
      if (i != int'(dd) - 1) step(1);
    end
    chk({tag, ".dly0"},   32'(dut.dly_q), 32'd0);
    chk({tag, ".req_lo"}, 32'(rs_req),    32'd0);
    step(1);
    chk({tag, ".req_hi"}, 32'(rs_req),        32'd1);
    chk({tag, ".send"},   32'(dut.state_q),   32'(ST_SEND));
  endtask

  initial begin
    // Reset state
    step(3);
    outs("rst", 0, 0, 0, 0);
    chk("rst.lfsr",  32'(dut.lfsr_q),  32'(SEED));
    chk("rst.state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b1;

    // Let the LFSR run until its low nibble gives a multi-ms delay
    for (int i = 0; i < 40 && m_lfsr[3:0] < 4'd2; i++) step(1);
    chk("lfsr.run", 32'(dut.lfsr_q), 32'(m_lfsr));

    // 1: enable, with a ms tick on the entry cycle that must not be applied
    d = m_lfsr[3:0];
    en = 1'b1; tick_ms = 1'b1; step(1); tick_ms = 1'b0;
    chk("t1.state", 32'(dut.state_q), 32'(ST_DELAY));
    chk("t1.dly",   32'(dut.dly_q),   32'(d));
    run_delay("t1", d);
    step(4);
    chk("t1.req_held", 32'(rs_req), 32'd1);
    rs_ack = 1'b1; step(1); rs_ack = 1'b0;
    outs("t1.ack", 0, 1, 0, 0);
    chk("t1.wait", 32'(dut.state_q), 32'(ST_WAIT));

    // Stray ack without a request is ignored
    rs_ack = 1'b1; step(1); rs_ack = 1'b0;
    chk("stray.cnt",   32'(rs_cnt),        32'd1);
    chk("stray.state", 32'(dut.state_q),   32'(ST_WAIT));

    // 2: unanswered burst, requests spaced by the interval
    for (int r = 2; r <= RS_MAX; r++) begin
      repeat (RS_INTERVAL_S - 1) tick_sec();
      chk($sformatf("t2.r%0d.early", r), 32'(rs_req), 32'd0);
      tick_sec();
      chk($sformatf("t2.r%0d.req", r), 32'(rs_req), 32'd1);
      rs_ack = 1'b1; step(1); rs_ack = 1'b0;
      outs($sformatf("t2.r%0d.ack", r), 0, r, 0, 0);
    end
    repeat (RS_INTERVAL_S - 1) tick_sec();
    chk("t2.prefail", 32'(rs_fail), 32'd0);
    tick_sec();
    outs("t2.fail", 0, RS_MAX, 1, 0);
    chk("t2.fstate", 32'(dut.state_q), 32'(ST_FAIL));
    repeat (RS_BACKOFF_S - 1) tick_sec();
    outs("t2.backoff", 0, RS_MAX, 1, 0);
    tick_sec();
    outs("t2.restart", 1, 0, 0, 0);
    rs_ack = 1'b1; step(1); rs_ack = 1'b0;
    outs("t2.ack1", 0, 1, 0, 0);

    // 3: router detected while waiting
    tick_sec();
    rtr_det = 1'b1; step(1);
    outs("t3.done", 0, 0, 0, 1);
    chk("t3.state", 32'(dut.state_q), 32'(ST_DONE));
    repeat (5) tick_sec();
    outs("t3.quiet", 0, 0, 0, 1);

    // 4: router expires, fresh random delay then a new request
    d = m_lfsr[3:0];
    rtr_det = 1'b0; step(1);
    outs("t4.expire", 0, 0, 0, 0);
    chk("t4.state", 32'(dut.state_q), 32'(ST_DELAY));
    chk("t4.dly",   32'(dut.dly_q),   32'(d));
    run_delay("t4", d);

    // 5: link drop on the ack cycle wins
    en = 1'b0; rs_ack = 1'b1; step(1); rs_ack = 1'b0;
    outs("t5.drop", 0, 0, 0, 0);
    chk("t5.state", 32'(dut.state_q), 32'(ST_IDLE));
    step(2);
    d = m_lfsr[3:0];
    en = 1'b1; step(1);
    chk("t5.state2", 32'(dut.state_q), 32'(ST_DELAY));
    chk("t5.dly",    32'(dut.dly_q),   32'(d));

    // 6: router already present on entering the delay
    en = 1'b0; step(1);
    rtr_det = 1'b1; en = 1'b1; step(1);
    chk("t6.delay",  32'(dut.state_q), 32'(ST_DELAY));
    chk("t6.req0",   32'(rs_req),      32'd0);
    step(1);
    outs("t6.done", 0, 0, 0, 1);
    chk("t6.state", 32'(dut.state_q), 32'(ST_DONE));
    step(3);
    chk("t6.req1", 32'(rs_req), 32'd0);

    // 6b: reset in the middle of a wait
    d = m_lfsr[3:0];
    rtr_det = 1'b0; step(1);
    run_delay("t6b", d);
    rs_ack = 1'b1; step(1); rs_ack = 1'b0;
    chk("t6b.wait", 32'(dut.state_q), 32'(ST_WAIT));
    chk("t6b.cnt",  32'(rs_cnt),      32'd1);
    repeat (2) tick_sec();
    rst = 1'b0; step(1);
    outs("t6b.rst", 0, 0, 0, 0);
    chk("t6b.lfsr",  32'(dut.lfsr_q),  32'(SEED));
    chk("t6b.state", 32'(dut.state_q), 32'(ST_IDLE));
    en = 1'b0; rst = 1'b1; step(2);
    chk("end.state", 32'(dut.state_q), 32'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
